ov7670_vga_frame_reader: RTL and testbench

- Display-side reader of the OV7670 frame buffer; the camera write controller fills the same 320x240 RGB565 memory.
- Generates 640x480@60 VGA timing from a 25 MHz pixel clock.
- Fetches each buffer word with 2x2 pixel replication: one buffer pixel drives a 2x2 block of screen pixels.
- Converts RGB565 to RGB444 and outputs syncs, data-enable and pixel coordinates, all aligned to the RGB data.

---
 rtl/ov7670_vga_frame_reader.sv | 127 ++++++++++++
 tb/tb_ov7670_vga_frame_reader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ov7670_vga_frame_reader.sv
// VGA-side reader of the OV7670 320x240 RGB565 frame buffer: 640x480 timing,
// 2x2 pixel replication, RGB444 output with all sideband signals aligned to the pixel data.
module ov7670_vga_frame_reader #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int MEM_LATENCY = 1
) (
   input  logic        pclk,
   input  logic        reset,
   output logic        oe,
   output logic [16:0] rAddr,
   input  logic [15:0] rData,
   output logic        h_sync,
   output logic        v_sync,
   output logic        de,
   output logic [9:0]  x_pixel,
   output logic [9:0]  y_pixel,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        frame_start
);

   localparam int PIPE = 2 + MEM_LATENCY;

   localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

   function automatic logic [11:0] rgb565_to_444(input logic [15:0] px);
      return {px[15:12], px[10:7], px[4:1]};
   endfunction

   logic [9:0]            h_cnt_p0_q, h_cnt_p0_d;
   logic [9:0]            v_cnt_p0_q, v_cnt_p0_d;
   logic                  vis_p0, hs_p0, vs_p0, fs_p0;
   logic [16:0]           row_p0;
   logic                  oe_p1_q, oe_p1_d;
   logic [16:0]           raddr_p1_q, raddr_p1_d;
   logic [PIPE-1:0]       vis_sr_q, vis_sr_d;
   logic [PIPE-1:0]       hs_sr_q, hs_sr_d;
   logic [PIPE-1:0]       vs_sr_q, vs_sr_d;
   logic [PIPE-1:0]       fs_sr_q, fs_sr_d;
   logic [PIPE-1:0][9:0]  x_sr_q, x_sr_d;
   logic [PIPE-1:0][9:0]  y_sr_q, y_sr_d;
   logic [11:0]           rgb_q, rgb_d;

   always_comb begin
      // Stage 0: raw counters and their decode
      h_cnt_p0_d = (h_cnt_p0_q == H_LAST) ? 10'd0 : h_cnt_p0_q + 10'd1;
      v_cnt_p0_d = v_cnt_p0_q;
      if (h_cnt_p0_q == H_LAST)
         v_cnt_p0_d = (v_cnt_p0_q == V_LAST) ? 10'd0 : v_cnt_p0_q + 10'd1;

      vis_p0 = (h_cnt_p0_q < H_VIS) && (v_cnt_p0_q < V_VIS);
      hs_p0  = !((h_cnt_p0_q >= HS_BEG) && (h_cnt_p0_q < HS_END));
      vs_p0  = !((v_cnt_p0_q >= VS_BEG) && (v_cnt_p0_q < VS_END));
      fs_p0  = (h_cnt_p0_q == 10'd0) && (v_cnt_p0_q == 10'd0);

      // Stage 1: buffer address, row*320 built from two shifts
      row_p0     = {8'd0, v_cnt_p0_q[9:1]};
      oe_p1_d    = vis_p0;
      raddr_p1_d = vis_p0 ? (row_p0 << 8) + (row_p0 << 6) + {8'd0, h_cnt_p0_q[9:1]} : 17'd0;

      vis_sr_d = {vis_sr_q[PIPE-2:0], vis_p0};
      hs_sr_d  = {hs_sr_q[PIPE-2:0], hs_p0};
      vs_sr_d  = {vs_sr_q[PIPE-2:0], vs_p0};
      fs_sr_d  = {fs_sr_q[PIPE-2:0], fs_p0};
      x_sr_d   = {x_sr_q[PIPE-2:0], h_cnt_p0_q};
      y_sr_d   = {y_sr_q[PIPE-2:0], v_cnt_p0_q};

      // Output stage: rData arrives while the matching de sits one slot before the output
      rgb_d = vis_sr_q[PIPE-2] ? rgb565_to_444(rData) : 12'd0;
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         h_cnt_p0_q <= '0;
         v_cnt_p0_q <= '0;
         oe_p1_q    <= 1'b0;
         raddr_p1_q <= '0;
         vis_sr_q   <= '0;
         hs_sr_q    <= '1;
         vs_sr_q    <= '1;
         fs_sr_q    <= '0;
         x_sr_q     <= '0;
         y_sr_q     <= '0;
         rgb_q      <= '0;
      end else begin
         h_cnt_p0_q <= h_cnt_p0_d;
         v_cnt_p0_q <= v_cnt_p0_d;
         oe_p1_q    <= oe_p1_d;
         raddr_p1_q <= raddr_p1_d;
         vis_sr_q   <= vis_sr_d;
         hs_sr_q    <= hs_sr_d;
         vs_sr_q    <= vs_sr_d;
         fs_sr_q    <= fs_sr_d;
         x_sr_q     <= x_sr_d;
         y_sr_q     <= y_sr_d;
         rgb_q      <= rgb_d;
      end
   end

   assign oe          = oe_p1_q;
   assign rAddr       = raddr_p1_q;
   assign h_sync      = hs_sr_q[PIPE-1];
   assign v_sync      = vs_sr_q[PIPE-1];
   assign de          = vis_sr_q[PIPE-1];
   assign frame_start = fs_sr_q[PIPE-1];
   assign x_pixel     = x_sr_q[PIPE-1];
   assign y_pixel     = y_sr_q[PIPE-1];
   assign red         = rgb_q[11:8];
   assign green       = rgb_q[7:4];
   assign blue        = rgb_q[3:0];

endmodule

// File: tb/tb_ov7670_vga_frame_reader.sv
// Bench for ov7670_vga_frame_reader: full-size builds with one- and two-cycle memories plus a
// shrunken-geometry build for frame-level timing, all checked against a pixel-index model.
module tb_ov7670_vga_frame_reader;

   logic pclk = 1'b0;
   logic reset = 1'b1;
   logic const_mode = 1'b1;
   logic [15:0] mem [0:76799];

   always #20 pclk = ~pclk;

   logic oe1, hs1, vs1, de1, fs1; logic [16:0] ra1; logic [15:0] rd1;
   logic [9:0] x1, y1; logic [3:0] r1, g1, b1;
   logic oe2, hs2, vs2, de2, fs2; logic [16:0] ra2; logic [15:0] rd2;
   logic [9:0] x2, y2; logic [3:0] r2, g2, b2; logic [16:0] ra2_dly;
   logic oe3, hs3, vs3, de3, fs3; logic [16:0] ra3; logic [15:0] rd3;
   logic [9:0] x3, y3; logic [3:0] r3, g3, b3;

   ov7670_vga_frame_reader #(.MEM_LATENCY(1)) u_l1 (
      .pclk(pclk), .reset(reset), .oe(oe1), .rAddr(ra1), .rData(rd1),
      .h_sync(hs1), .v_sync(vs1), .de(de1), .x_pixel(x1), .y_pixel(y1),
      .red(r1), .green(g1), .blue(b1), .frame_start(fs1));

   ov7670_vga_frame_reader #(.MEM_LATENCY(2)) u_l2 (
      .pclk(pclk), .reset(reset), .oe(oe2), .rAddr(ra2), .rData(rd2),
      .h_sync(hs2), .v_sync(vs2), .de(de2), .x_pixel(x2), .y_pixel(y2),
      .red(r2), .green(g2), .blue(b2), .frame_start(fs2));

   ov7670_vga_frame_reader #(.H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .MEM_LATENCY(1)) u_small (
      .pclk(pclk), .reset(reset), .oe(oe3), .rAddr(ra3), .rData(rd3),
      .h_sync(hs3), .v_sync(vs3), .de(de3), .x_pixel(x3), .y_pixel(y3),
      .red(r3), .green(g3), .blue(b3), .frame_start(fs3));

   // Memory models: one-cycle BRAM and a two-cycle memory returning its own address
   always @(posedge pclk) begin
      rd1     <= const_mode ? 16'hF81F : mem[ra1];
      rd3     <= const_mode ? 16'hF81F : mem[ra3];
      ra2_dly <= ra2;
      rd2     <= ra2_dly[15:0];
   end

   int n = 0;
   int tests = 0;
   int fails = 0;
   int hs_low_cnt, hs_first, vs_low_cnt, fs_cnt;

   // Expected outputs after n clock edges since reset release, from the pixel index alone
   function automatic logic [53:0] model(input int cyc, input int hv, input int hf, input int hsw,
                                         input int hb, input int vv, input int vf, input int vsw,
                                         input int vb, input int pipe, input bit addr_data);
      int ht, vt, p, h, v, a;
      logic e_oe, e_hs, e_vs, e_de, e_fs;
      logic [16:0] e_a; logic [9:0] e_x, e_y; logic [11:0] e_rgb; logic [15:0] w;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      e_oe = 0; e_a = 0; e_hs = 1; e_vs = 1; e_de = 0; e_x = 0; e_y = 0; e_rgb = 0; e_fs = 0;
      if (cyc >= 1) begin
         p = cyc - 1; h = p % ht; v = (p / ht) % vt;
         if (h < hv && v < vv) begin
            e_oe = 1; e_a = 17'((v / 2) * 320 + h / 2);
         end
      end
      if (cyc >= pipe) begin
         p = cyc - pipe; h = p % ht; v = (p / ht) % vt;
         e_de = (h < hv) && (v < vv);
         e_hs = !(h >= hv + hf && h < hv + hf + hsw);
         e_vs = !(v >= vv + vf && v < vv + vf + vsw);
         e_x = 10'(h); e_y = 10'(v);
         e_fs = (h == 0) && (v == 0);
         if (e_de) begin
            a = (v / 2) * 320 + h / 2;
            w = addr_data ? 16'(a) : (const_mode ? 16'hF81F : mem[a]);
            e_rgb = {w[15:12], w[10:7], w[4:1]};
         end
      end
      return {e_oe, e_a, e_hs, e_vs, e_de, e_x, e_y, e_rgb, e_fs};
   endfunction

   task automatic check_all();
      logic [53:0] got, exp;
      got = {oe1, ra1, hs1, vs1, de1, x1, y1, r1, g1, b1, fs1};
      exp = model(n, 640, 16, 96, 48, 480, 10, 2, 33, 3, 1'b0);
      tests++;
      assert (got === exp) else begin
         fails++; $error("FAIL l1 n=%0d got=%h expected=%h", n, got, exp);
      end
      got = {oe2, ra2, hs2, vs2, de2, x2, y2, r2, g2, b2, fs2};
      exp = model(n, 640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b1);
      tests++;
      assert (got === exp) else begin
         fails++; $error("FAIL l2 n=%0d got=%h expected=%h", n, got, exp);
      end
      got = {oe3, ra3, hs3, vs3, de3, x3, y3, r3, g3, b3, fs3};
      exp = model(n, 16, 2, 4, 3, 8, 1, 2, 2, 3, 1'b0);
      tests++;
      assert (got === exp) else begin
         fails++; $error("FAIL small n=%0d got=%h expected=%h", n, got, exp);
      end
   endtask

   task automatic check_eq(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++; $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic assert_reset_now();
      #7 reset = 1'b1;
      n = 0;
      #1 check_all();
   endtask

   task automatic release_and_run(input int cycles);
      int start_addr [4];
      start_addr = '{0, 0, 1, 1};
      hs_low_cnt = 0; hs_first = -1; vs_low_cnt = 0; fs_cnt = 0;
      @(negedge pclk);
      #5 reset = 1'b0;
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge pclk);
         n++;
         check_all();
         if (n >= 1 && n <= 4) check_eq("start_raddr", int'(ra1), start_addr[n-1]);
         if (n == 1) check_eq("start_oe", int'(oe1), 1);
         if (n == 2) check_eq("de_before_pipe", int'(de1), 0);
         if (n == 3) check_eq("first_pixel", int'({de1, fs1, x1, y1}), int'({2'b11, 20'd0}));
         if (n == 641) check_eq("oe_hblank", int'(oe1), 0);
         if (n == 801) check_eq("row1_raddr", int'(ra1), 0);
         if (n == 1601) check_eq("row2_raddr", int'(ra1), 320);
         if (n == 4) check_eq("l2_first_pixel", int'({de2, fs2}), 3);
         if (n >= 3 && n <= 802 && !hs1) begin
            hs_low_cnt++;
            if (hs_first < 0) hs_first = n;
         end
         if (n >= 3 && n < 3 + 325 && !vs3) vs_low_cnt++;
         if (fs3) fs_cnt++;
      end
      check_eq("hsync_low_len", hs_low_cnt, 96);
      check_eq("hsync_first", hs_first, 659);
      check_eq("small_vsync_len", vs_low_cnt, 50);
      check_eq("small_fs_count", fs_cnt, (n - 3) / 325 + 1);
   endtask

   initial begin
      for (int i = 0; i < 76800; i++) mem[i] = 16'($urandom);
      repeat (3) @(negedge pclk);
      check_all();
      // Constant-colour frame start
      release_and_run(1700 + $urandom_range(0, 200));
      // Mid-line asynchronous reset, then random buffer contents
      @(negedge pclk);
      assert_reset_now();
      repeat (2) @(negedge pclk);
      const_mode = 1'b0;
      release_and_run(1700 + $urandom_range(0, 600));
      // Second random restart point
      @(negedge pclk);
      assert_reset_now();
      @(negedge pclk);
      for (int i = 0; i < 76800; i++) mem[i] = 16'($urandom);
      release_and_run(1650 + $urandom_range(0, 400));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
